// File: rtl/redirect_pkg.sv
// Shared types and default widths for the branch-redirect sequencer.
package redirect_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int CNT_W_DEF  = 2;
  localparam int PERF_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    DRAIN = 2'd2
  } redir_state_e;

  function automatic logic is_mispred(
    input logic        valid,
    input logic        is_ctrl,
    input logic [63:0] target,
    input logic [63:0] pred_npc
  );
    return valid & is_ctrl & (target != pred_npc);
  endfunction

endpackage

// File: rtl/redirect_ctrl_chk.sv
// Protocol checker for redirect_ctrl: stale responses must be accounted for.
module redirect_ctrl_chk #(
  parameter int CNT_W = 2
) (
  input logic             clk,
  input logic             rst_n,
  input logic [1:0]       i_state,
  input logic [CNT_W-1:0] i_stale_cnt,
  input logic             i_rsp_valid
);

  // A response outside IDLE with nothing outstanding means the IFU lied about inflight.
  a_rsp_accounted: assert property (@(posedge clk) disable iff (!rst_n)
    ((i_state != 2'd0) && i_rsp_valid) |-> (i_stale_cnt != '0));

  a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
    i_state != 2'd3);

endmodule

// File: rtl/redirect_perf_cnt.sv
// Saturating event counter; cleared only by the asynchronous reset.
module redirect_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count events, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/redirect_ctrl.sv
// Branch-redirect sequencer between EX-stage BRU and IFU.
// Optional perf counters are built when REDIRECT_PERF_EN is defined.
module redirect_ctrl
  import redirect_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PERF_W = PERF_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_is_ctrl,
  input  logic [XLEN-1:0]   ex_target,
  input  logic [XLEN-1:0]   ex_pred_npc,
  output logic              ex_ready,
  output logic              flush,
  output logic              redir_valid,
  output logic [XLEN-1:0]   redir_pc,
  input  logic              redir_ready,
  input  logic [CNT_W-1:0]  ifu_inflight,
  input  logic              ifu_rsp_valid,
  output logic              drop_rsp
`ifdef REDIRECT_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_ctrl_cnt,
  output logic [PERF_W-1:0] perf_redir_cnt
`endif
);

  redir_state_e     r_state;
  redir_state_e     w_state_nxt;
  logic [CNT_W-1:0] r_stale_cnt;
  logic [CNT_W-1:0] w_stale_nxt;
  logic [CNT_W-1:0] w_stale_dec;
  logic [XLEN-1:0]  r_redir_pc;
  logic             w_mispred;
  logic             w_take;
  logic             w_ex_ready;
  logic             w_flush;
  logic             w_redir_valid;
  logic             w_drop;

  assign w_mispred   = is_mispred(ex_valid, ex_is_ctrl, 64'(ex_target), 64'(ex_pred_npc));
  assign w_take      = (r_state == IDLE) & w_mispred;
  // Floor at zero: an unaccounted response must not wrap the counter.
  assign w_stale_dec = (ifu_rsp_valid && (r_stale_cnt != '0)) ? (r_stale_cnt - CNT_W'(1))
                                                              : r_stale_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; exit decisions use the post-decrement stale count.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_mispred) w_state_nxt = REDIR;
        else           w_state_nxt = IDLE;
      end
      REDIR: begin
        if (redir_ready) w_state_nxt = (w_stale_dec == '0) ? IDLE : DRAIN;
        else             w_state_nxt = REDIR;
      end
      DRAIN: begin
        if (w_stale_dec == '0) w_state_nxt = IDLE;
        else                   w_state_nxt = DRAIN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stale-count next value.
  always_comb begin
    w_stale_nxt = r_stale_cnt;
    case (r_state)
      IDLE: begin
        if (w_mispred) w_stale_nxt = ifu_inflight;
        else           w_stale_nxt = r_stale_cnt;
      end
      REDIR:   w_stale_nxt = w_stale_dec;
      DRAIN:   w_stale_nxt = w_stale_dec;
      default: w_stale_nxt = '0;
    endcase
  end

  // Redirect target and stale-response counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redir_pc  <= '0;
      r_stale_cnt <= '0;
    end else begin
      r_stale_cnt <= w_stale_nxt;
      if (w_take) r_redir_pc <= ex_target;
      else        r_redir_pc <= r_redir_pc;
    end
  end

  // Output decode.
  always_comb begin
    w_ex_ready    = 1'b1;
    w_flush       = 1'b0;
    w_redir_valid = 1'b0;
    w_drop        = 1'b0;
    case (r_state)
      IDLE: begin
        w_flush = w_mispred;
        w_drop  = w_mispred & ifu_rsp_valid;
      end
      REDIR: begin
        w_ex_ready    = 1'b0;
        w_redir_valid = 1'b1;
        w_drop        = ifu_rsp_valid;
      end
      DRAIN: begin
        w_drop = ifu_rsp_valid;
      end
      default: begin
        w_ex_ready    = 1'b1;
        w_redir_valid = 1'b0;
      end
    endcase
  end

  // Combinational kills are masked while reset is held.
  assign ex_ready    = w_ex_ready;
  assign flush       = w_flush & rst_n;
  assign redir_valid = w_redir_valid;
  assign drop_rsp    = w_drop & rst_n;
  assign redir_pc    = r_redir_pc;

`ifdef REDIRECT_PERF_EN
  logic w_ctrl_inc;

  assign w_ctrl_inc = (r_state == IDLE) & ex_valid & ex_is_ctrl;

  redirect_perf_cnt #(.W(PERF_W)) u_perf_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_ctrl_inc),
    .o_cnt (perf_ctrl_cnt)
  );

  redirect_perf_cnt #(.W(PERF_W)) u_perf_redir (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_take),
    .o_cnt (perf_redir_cnt)
  );
`endif

  redirect_ctrl_chk #(.CNT_W(CNT_W)) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_state     (r_state),
    .i_stale_cnt (r_stale_cnt),
    .i_rsp_valid (ifu_rsp_valid)
  );

endmodule

// File: tb/tb_redirect_ctrl.sv
// Self-checking bench for redirect_ctrl: directed vector table, reset/perf sequences,
// and randomized traffic against a behavioural model.
module tb_redirect_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_is_ctrl;
  logic [31:0] ex_target;
  logic [31:0] ex_pred_npc;
  logic        ex_ready;
  logic        flush;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;
  logic [1:0]  ifu_inflight;
  logic        ifu_rsp_valid;
  logic        drop_rsp;
`ifdef REDIRECT_PERF_EN
  logic [31:0] perf_ctrl_cnt;
  logic [31:0] perf_redir_cnt;
`endif

  redirect_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_is_ctrl    (ex_is_ctrl),
    .ex_target     (ex_target),
    .ex_pred_npc   (ex_pred_npc),
    .ex_ready      (ex_ready),
    .flush         (flush),
    .redir_valid   (redir_valid),
    .redir_pc      (redir_pc),
    .redir_ready   (redir_ready),
    .ifu_inflight  (ifu_inflight),
    .ifu_rsp_valid (ifu_rsp_valid),
    .drop_rsp      (drop_rsp)
`ifdef REDIRECT_PERF_EN
    ,
    .perf_ctrl_cnt (perf_ctrl_cnt),
    .perf_redir_cnt(perf_redir_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: a pending redirect plus a number of stale responses still owed.
  bit          m_pend;
  int          m_stale;
  logic [31:0] m_pc;

  typedef struct {
    logic        v;
    logic        c;
    logic [31:0] t;
    logic [31:0] p;
    logic [1:0]  infl;
    logic        rdy;
    logic        rsp;
    logic        e_rdy;
    logic        e_flush;
    logic        e_rv;
    logic [31:0] e_pc;
    logic        e_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic c, input logic [31:0] t, input logic [31:0] p,
                       input logic [1:0] infl, input logic rdy, input logic rsp);
    ex_valid      = v;
    ex_is_ctrl    = c;
    ex_target     = t;
    ex_pred_npc   = p;
    ifu_inflight  = infl;
    redir_ready   = rdy;
    ifu_rsp_valid = rsp;
  endtask

  task automatic model_reset();
    m_pend  = 1'b0;
    m_stale = 0;
    m_pc    = 32'h0;
  endtask

  task automatic model_update();
    if (m_pend) begin
      if (ifu_rsp_valid && m_stale > 0) m_stale--;
      if (redir_ready) m_pend = 1'b0;
    end else if (m_stale > 0) begin
      if (ifu_rsp_valid) m_stale--;
    end else if (ex_valid && ex_is_ctrl && (ex_target != ex_pred_npc)) begin
      m_pend  = 1'b1;
      m_pc    = ex_target;
      m_stale = int'(ifu_inflight);
    end
  endtask

  task automatic model_check(input string tag);
    logic mis;
    mis = ex_valid & ex_is_ctrl & (ex_target != ex_pred_npc);
    if (m_pend) begin
      chk({tag, " ex_ready"}, 32'(ex_ready), 32'd0);
      chk({tag, " flush"}, 32'(flush), 32'd0);
      chk({tag, " redir_valid"}, 32'(redir_valid), 32'd1);
      chk({tag, " redir_pc"}, redir_pc, m_pc);
      chk({tag, " drop_rsp"}, 32'(drop_rsp), 32'(ifu_rsp_valid));
    end else if (m_stale > 0) begin
      chk({tag, " ex_ready"}, 32'(ex_ready), 32'd1);
      chk({tag, " flush"}, 32'(flush), 32'd0);
      chk({tag, " redir_valid"}, 32'(redir_valid), 32'd0);
      chk({tag, " drop_rsp"}, 32'(drop_rsp), 32'(ifu_rsp_valid));
    end else begin
      chk({tag, " ex_ready"}, 32'(ex_ready), 32'd1);
      chk({tag, " flush"}, 32'(flush), 32'(mis));
      chk({tag, " redir_valid"}, 32'(redir_valid), 32'd0);
      chk({tag, " drop_rsp"}, 32'(drop_rsp), 32'(mis & ifu_rsp_valid));
    end
  endtask

  // One clock: sample at negedge, check against model, advance model, step past posedge.
  task automatic run_cycle(input string tag);
    @(negedge clk);
    model_check(tag);
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    // Directed vectors, applied back-to-back as one continuous sequence.
    vecs.push_back('{1'b1, 1'b1, 32'h8000_0010, 32'h8000_0010, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h8000_0040, 32'h8000_0014, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h8000_0100, 32'h8000_0008, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h8000_0200, 32'h8000_0004, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0200, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0200, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h8000_0500, 32'h8000_0504, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0200, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0200, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h8000_0400, 32'h8000_0404, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h8000_0300, 32'h8000_0008, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0300, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0});

    // Reset with a would-be mispredict and a response presented: all kills suppressed.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 32'h1234_0000, 32'h1234_0004, 2'd3, 1'b1, 1'b1);
    #12;
    chk("reset ex_ready", 32'(ex_ready), 32'd1);
    chk("reset flush", 32'(flush), 32'd0);
    chk("reset redir_valid", 32'(redir_valid), 32'd0);
    chk("reset drop_rsp", 32'(drop_rsp), 32'd0);
    chk("reset redir_pc", redir_pc, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].c, vecs[i].t, vecs[i].p, vecs[i].infl, vecs[i].rdy, vecs[i].rsp);
      @(negedge clk);
      chk($sformatf("vec%0d ex_ready", i), 32'(ex_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d flush", i), 32'(flush), 32'(vecs[i].e_flush));
      chk($sformatf("vec%0d redir_valid", i), 32'(redir_valid), 32'(vecs[i].e_rv));
      chk($sformatf("vec%0d drop_rsp", i), 32'(drop_rsp), 32'(vecs[i].e_drop));
      if (vecs[i].e_rv) chk($sformatf("vec%0d redir_pc", i), redir_pc, vecs[i].e_pc);
      model_update();
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a held redirect.
    drive(1'b1, 1'b1, 32'h8000_0700, 32'h8000_0004, 2'd1, 1'b0, 1'b0);
    run_cycle("rst_mid detect");
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    chk("rst_mid pre redir_valid", 32'(redir_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid redir_valid", 32'(redir_valid), 32'd0);
    chk("rst_mid ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_mid redir_pc", redir_pc, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1);
    run_cycle("rst_mid after");

    // Randomized traffic; responses outside IDLE only while stale ones are owed.
    for (int n = 0; n < 800; n++) begin
      logic [31:0] t;
      logic        rsp;
      t = $urandom & 32'hFFFF_FFFC;
      if (m_pend || m_stale > 0) rsp = (m_stale > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      else                       rsp = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t,
            ($urandom_range(0, 1) == 0) ? t : t + 32'd4,
            2'($urandom_range(0, 3)),
            m_pend ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1)),
            rsp);
      run_cycle("rand");
    end

`ifdef REDIRECT_PERF_EN
    // Five control instructions, two of them mispredicted.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    #3;
    chk("perf reset ctrl", perf_ctrl_cnt, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      logic [31:0] pc;
      pc = 32'h8000_1000 + 32'(k) * 32'h10;
      drive(1'b1, 1'b1, pc, ((k == 1) || (k == 3)) ? pc + 32'd8 : pc, 2'd0, 1'b0, 1'b0);
      run_cycle("perf instr");
      if ((k == 1) || (k == 3)) begin
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);
        run_cycle("perf accept");
      end
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("perf_ctrl_cnt", perf_ctrl_cnt, 32'd5);
    chk("perf_redir_cnt", perf_redir_cnt, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
